// File: rtl/minbd_pkg.sv
// Shared MinBD router definitions: flit width, channel indices, flit type,
// and the deflected-flit priority picker used by the side-buffer capture.
package minbd_pkg;

    localparam int FLIT_W = 11;

    localparam int DIR_E = 0;
    localparam int DIR_W = 1;
    localparam int DIR_N = 2;
    localparam int DIR_S = 3;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } sel_t;

    // Lowest set index wins: east > west > north > south.
    function automatic sel_t prio_sel(input logic [3:0] cand);
        sel_t s;
        s.hit = 1'b0;
        s.idx = 2'(DIR_E);
        for (int i = DIR_S; i >= DIR_E; i--) begin
            if (cand[i]) begin
                s.hit = 1'b1;
                s.idx = 2'(i);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/sbcapture_sbfifo.sv
// Side-buffer FIFO: registered head, separate occupancy count, and
// simultaneous push/pop. Pointers wrap naturally (DEPTH is a power of two).
module sbfifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [W-1:0]     i_data,
    input  logic             i_pop,
    output logic [W-1:0]     o_head,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count,
    output logic [CNT_W-1:0] o_count_nxt
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [W-1:0]     r_head;

    logic             w_pop;
    logic             w_push;
    logic [PTR_W-1:0] w_rd_inc;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [W-1:0]     w_head_nxt;

    assign w_pop     = i_pop & (r_count != '0);
    assign w_push    = i_push & ((r_count != CNT_W'(DEPTH)) | w_pop);
    assign w_rd_inc  = r_rd_ptr + PTR_W'(1);
    assign w_cnt_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Next head: a push lands directly in the head when the buffer is (or is
    // about to become) empty; otherwise a pop exposes the next stored entry.
    always_comb begin
        w_head_nxt = r_head;
        if (w_cnt_nxt == '0)
            w_head_nxt = '0;
        else if (w_push && ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop)))
            w_head_nxt = i_data;
        else if (w_pop)
            w_head_nxt = r_mem[w_rd_inc];
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers, occupancy and head register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= w_rd_inc;
            r_count <= w_cnt_nxt;
            r_head  <= w_head_nxt;
        end
    end

    assign o_head      = r_head;
    assign o_valid     = (r_count != '0);
    assign o_count     = r_count;
    assign o_count_nxt = w_cnt_nxt;

endmodule

// File: rtl/sbcapture.sv
// Side-buffer capture stage: pulls at most one deflected flit per cycle off
// the four output channels into the side buffer, registers the channels, and
// raises redirect when the buffer has sat full for too long.
import minbd_pkg::*;

module sbcapture #(
    parameter int FLIT_W       = minbd_pkg::FLIT_W,
    parameter int DEPTH        = 4,
    parameter int REDIR_THRESH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4*FLIT_W-1:0]        in_flit,
    input  logic [3:0]                 in_valid,
    input  logic [3:0]                 in_defl,
    output logic [4*FLIT_W-1:0]        out_flit,
    output logic [3:0]                 out_valid,
    output logic [FLIT_W-1:0]          sbinject,
    output logic                       sbinject_valid,
    input  logic                       sbinject_take,
    output logic                       redirect,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int RC_W  = $clog2(REDIR_THRESH+1);

    sel_t              w_sel;
    logic              w_pop;
    logic              w_space;
    logic              w_push;
    logic [3:0]        w_cap_mask;
    logic [FLIT_W-1:0] w_cap_flit;
    logic [4*FLIT_W-1:0] w_out_flit_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [RC_W-1:0]   w_redir_nxt;

    logic [4*FLIT_W-1:0] r_out_flit;
    logic [3:0]          r_out_valid;
    logic [RC_W-1:0]     r_redir_cnt;
    logic                r_redirect;

    assign w_sel   = prio_sel(in_valid & in_defl);
    assign w_pop   = sbinject_take & sbinject_valid;
    // A full buffer still accepts a capture when the head leaves this cycle.
    assign w_space = (count != CNT_W'(DEPTH)) | w_pop;
    assign w_push  = w_sel.hit & w_space;

    // Decode the captured channel, mux out its flit and blank it on the link.
    always_comb begin
        w_cap_mask     = '0;
        w_cap_flit     = '0;
        w_out_flit_nxt = in_flit;
        for (int i = 0; i < 4; i++) begin
            if (w_push && (w_sel.idx == 2'(i))) begin
                w_cap_mask[i]                  = 1'b1;
                w_cap_flit                     = in_flit[i*FLIT_W +: FLIT_W];
                w_out_flit_nxt[i*FLIT_W +: FLIT_W] = '0;
            end
        end
    end

    sbfifo #(
        .W     (FLIT_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_data      (w_cap_flit),
        .i_pop       (sbinject_take),
        .o_head      (sbinject),
        .o_valid     (sbinject_valid),
        .o_count     (count),
        .o_count_nxt (w_cnt_nxt)
    );

    // Full-streak counter: counts edges that end full, saturating at threshold.
    always_comb begin
        w_redir_nxt = '0;
        if (w_cnt_nxt == CNT_W'(DEPTH)) begin
            w_redir_nxt = r_redir_cnt;
            if (r_redir_cnt != RC_W'(REDIR_THRESH))
                w_redir_nxt = r_redir_cnt + RC_W'(1);
        end
    end

    // Channel output register and redirect state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_flit  <= '0;
            r_out_valid <= '0;
            r_redir_cnt <= '0;
            r_redirect  <= 1'b0;
        end else begin
            r_out_flit  <= w_out_flit_nxt;
            r_out_valid <= in_valid & ~w_cap_mask;
            r_redir_cnt <= w_redir_nxt;
            r_redirect  <= (w_redir_nxt == RC_W'(REDIR_THRESH));
        end
    end

    assign out_flit  = r_out_flit;
    assign out_valid = r_out_valid;
    assign redirect  = r_redirect;

endmodule
